fifo_write_arbiter: RTL and testbench
=====================================

// Module: fifo_write_arbiter
// PURPOSE
//  Shares the single write port of fifo_memory among NUM_REQ producers. Round-robin
//  grants whole bursts (up to MAX_BURST beats or until req_last) to one requester at a
//  time, honours FIFO full back-pressure via per-requester valid/ready, and releases a
//  stalled grant after STALL_TIMEOUT idle cycles. Sits directly in front of fifo_memory.
// PARAMETERS
//  NUM_REQ        4    number of producers (2..16)
//  DATA_WIDTH     8    beat width; matches fifo_memory DATA_WIDTH
//  MAX_BURST      4    max beats per grant (>=1)
//  STALL_TIMEOUT  8    consecutive cycles of granted req_valid low before forced release (>=1)
// PORTS
//  clk           in   1                     system clock, rising edge
//  rstn          in   1                     asynchronous reset, active-low
//  req_valid     in   NUM_REQ               per-requester beat valid
//  req_last      in   NUM_REQ               per-requester end-of-burst marker
//  req_data      in   NUM_REQ*DATA_WIDTH    packed beats, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready     out  NUM_REQ               beat accepted when req_valid[i] & req_ready[i]
//  full          in   1                     from fifo_memory
//  write_enable  out  1                     to fifo_memory
//  write_data    out  DATA_WIDTH            to fifo_memory
//  grant_valid   out  1                     a burst is in progress
//  grant_id      out  ID_W                  current/last granted requester, ID_W = max(1,$clog2(NUM_REQ))
// BEHAVIOUR
//  Reset (rstn=0, async): state=IDLE, grant_valid=0, grant_id=0, rr pointer=0, beat and
//   stall counters=0; req_ready=0, write_enable=0 (combinational from state, so 0 at once).
//  States: IDLE, BURST.
//  IDLE: req_ready=0, write_enable=0. If any req_valid: pick first set bit scanning from
//   rr pointer upward with wrap; register grant_id, grant_valid=1, go BURST. 1-cycle grant latency.
//  BURST (g=grant_id): req_ready[g]=~full, all other req_ready=0;
//   write_enable = req_valid[g] & ~full (combinational); write_data = req_data[g] (always muxed).
//   Accepted beat increments beat counter; stall counter clears on any cycle req_valid[g]=1,
//   increments otherwise. Full with req_valid[g]=1 is not a stall.
//  Release (-> IDLE, grant_valid=0, rr pointer=(g+1) mod NUM_REQ, counters cleared) when:
//   accepted beat with req_last[g]=1; or accepted beat making count==MAX_BURST;
//   or stall counter reaches STALL_TIMEOUT. The releasing beat is still written.
//  grant_id holds last value in IDLE. Back-to-back bursts separated by exactly one IDLE cycle.
//  Never write_enable while full=1; never more than one req_ready high.
//  Requesters must hold req_data/req_last stable while valid & ~ready.
//  Reset mid-burst: burst abandoned, no write issued during or after reset; pointer to 0.
// STRUCTURE
//  Package fifo_arb_pkg: state enum (ARB_IDLE, ARB_BURST), id_width function (max(1,clog2)).
//  Sub-module rr_priority_picker: combinational; inputs req[NUM_REQ], ptr[ID_W];
//   outputs any, idx[ID_W] (first set bit at or above ptr, wrapping). Top holds FSM,
//   counters, data mux.
// TESTING  (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4, STALL_TIMEOUT=8, fifo_memory ADDR_WIDTH=4)
//  1 Single req1 sends A0,A1,A2 with last on A2 -> grant_id=1 next cycle, 3 writes in order,
//    release after A2, one IDLE cycle, rr pointer=2.
//  2 All four valid, no last -> grants 0,1,2,3,0 in order, exactly 4 beats each, FIFO
//    contents interleave in 4-beat groups.
//  3 Fill 16-entry FIFO from req0 with consumer off -> at full, write_enable=0, req_ready[0]=0,
//    no beat lost; read one entry -> exactly one more beat accepted.
//  4 req2 granted then drops valid for 8 cycles -> forced release on 8th cycle, grant moves to
//    waiting req3; no write during stall.
//  5 rstn pulsed low mid-burst (beat 2 of 4) -> write_enable, req_ready, grant_valid low
//    immediately; after release req0 wins first arbitration when req0 and req3 both valid.
//  6 Random valid/last/full for 10k cycles -> scoreboard: per-requester order preserved,
//    one-hot-or-zero req_ready, no write while full, burst length <= 4.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_e;

   // Requester index width, never narrower than one bit.
   function automatic int unsigned id_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first asserted request at or above ptr, wrapping to the bottom.
module rr_priority_picker
   import fifo_arb_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic               any,
   output logic [ID_W-1:0]    idx
);

   always_comb begin
      any = 1'b0;
      idx = '0;
      // Upper segment [ptr, NUM_REQ) has priority over the wrapped segment.
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (!any && req[j] && (ID_W'(j) >= ptr)) begin
            any = 1'b1;
            idx = ID_W'(j);
         end
      end
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (!any && req[j]) begin
            any = 1'b1;
            idx = ID_W'(j);
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing the fifo_memory write port among NUM_REQ producers,
// with full back-pressure and forced release of stalled grants.
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int unsigned NUM_REQ       = 4,
   parameter  int unsigned DATA_WIDTH    = 8,
   parameter  int unsigned MAX_BURST     = 4,
   parameter  int unsigned STALL_TIMEOUT = 8,
   localparam int unsigned ID_W          = id_width(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          full,
   output logic                          write_enable,
   output logic [DATA_WIDTH-1:0]         write_data,
   output logic                          grant_valid,
   output logic [ID_W-1:0]               grant_id
);

   localparam int unsigned BEAT_W  = $clog2(MAX_BURST + 1);
   localparam int unsigned STALL_W = $clog2(STALL_TIMEOUT + 1);

   arb_state_e          r_state,     w_state_nxt;
   logic [ID_W-1:0]     r_grant_id,  w_grant_id_nxt;
   logic [ID_W-1:0]     r_ptr,       w_ptr_nxt;
   logic [BEAT_W-1:0]   r_beat_cnt,  w_beat_cnt_nxt;
   logic [STALL_W-1:0]  r_stall_cnt, w_stall_cnt_nxt;

   logic                w_pick_any;
   logic [ID_W-1:0]     w_pick_idx;
   logic                w_g_valid;
   logic                w_g_last;
   logic                w_accept;
   logic                w_release;
   logic [ID_W-1:0]     w_ptr_after;

   rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .req (req_valid),
      .ptr (r_ptr),
      .any (w_pick_any),
      .idx (w_pick_idx)
   );

   // Granted requester's handshake signals and data.
   always_comb begin
      w_g_valid  = 1'b0;
      w_g_last   = 1'b0;
      write_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (ID_W'(i) == r_grant_id) begin
            w_g_valid  = req_valid[i];
            w_g_last   = req_last[i];
            write_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign w_accept    = (r_state == ARB_BURST) & w_g_valid & ~full;
   assign w_release   = (w_accept & (w_g_last | (r_beat_cnt == BEAT_W'(MAX_BURST - 1))))
                      | ((r_state == ARB_BURST) & ~w_g_valid
                         & (r_stall_cnt == STALL_W'(STALL_TIMEOUT - 1)));
   assign w_ptr_after = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + ID_W'(1);
   assign grant_valid = (r_state == ARB_BURST);
   assign grant_id    = r_grant_id;

   // Next-state, counters and handshake outputs.
   always_comb begin
      w_state_nxt     = r_state;
      w_grant_id_nxt  = r_grant_id;
      w_ptr_nxt       = r_ptr;
      w_beat_cnt_nxt  = r_beat_cnt;
      w_stall_cnt_nxt = r_stall_cnt;
      req_ready       = '0;
      write_enable    = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (w_pick_any) begin
               w_grant_id_nxt = w_pick_idx;
               w_state_nxt    = ARB_BURST;
            end
         end
         ARB_BURST: begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
               req_ready[i] = (ID_W'(i) == r_grant_id) & ~full;
            end
            write_enable    = w_accept;
            // Back-pressure with valid held is not a stall.
            w_stall_cnt_nxt = w_g_valid ? '0 : r_stall_cnt + STALL_W'(1);
            if (w_accept) begin
               w_beat_cnt_nxt = r_beat_cnt + BEAT_W'(1);
            end
            if (w_release) begin
               w_state_nxt     = ARB_IDLE;
               w_ptr_nxt       = w_ptr_after;
               w_beat_cnt_nxt  = '0;
               w_stall_cnt_nxt = '0;
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= ARB_IDLE;
         r_grant_id  <= '0;
         r_ptr       <= '0;
         r_beat_cnt  <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_grant_id  <= w_grant_id_nxt;
         r_ptr       <= w_ptr_nxt;
         r_beat_cnt  <= w_beat_cnt_nxt;
         r_stall_cnt <= w_stall_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: producer queues, a 16-deep FIFO model and
// per-requester expected-data queues checked on every write.
module tb_fifo_write_arbiter;

   localparam int unsigned NR    = 4;
   localparam int unsigned DW    = 8;
   localparam int unsigned MB    = 4;
   localparam int unsigned ST    = 8;
   localparam int unsigned DEPTH = 16;

   logic              clk = 1'b0;
   logic              rstn;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_last;
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     req_ready;
   logic              full;
   logic              write_enable;
   logic [DW-1:0]     write_data;
   logic              grant_valid;
   logic [1:0]        grant_id;

   fifo_write_arbiter #(
      .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB), .STALL_TIMEOUT(ST)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .req_valid    (req_valid),
      .req_last     (req_last),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .full         (full),
      .write_enable (write_enable),
      .write_data   (write_data),
      .grant_valid  (grant_valid),
      .grant_id     (grant_id)
   );

   always #5 clk = ~clk;

   logic [8:0]    src_q [NR][$];   // {last, data} waiting at each producer
   logic [7:0]    exp_q [NR][$];   // data expected on the write port, per producer
   logic [7:0]    fifo_q[$];
   int            grant_log[$];
   int            len_log[$];
   int            wr_log[$];
   logic [NR-1:0] gate;
   bit            rd;
   int            seq [NR];
   int            burst_beats;
   bit            prev_gv;
   int            n_checks;
   int            n_pass;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic queue_burst(input int r, input int n, input bit last_end);
      logic [7:0] d;
      for (int k = 0; k < n; k++) begin
         d = 8'((r << 6) | (seq[r] & 63));
         src_q[r].push_back({last_end && (k == n - 1), d});
         exp_q[r].push_back(d);
         seq[r]++;
      end
   endtask

   function automatic bit src_pending();
      for (int i = 0; i < NR; i++) if (src_q[i].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < NR; i++) begin
         src_q[i].delete();
         exp_q[i].delete();
      end
      fifo_q.delete();
      grant_log.delete();
      len_log.delete();
      wr_log.delete();
      burst_beats = 0;
      prev_gv     = 1'b0;
   endtask

   // One clock: drive at negedge, sample 1ns later, update the models for the coming posedge.
   task automatic step();
      int         g;
      logic [7:0] e;
      @(negedge clk);
      full = (fifo_q.size() >= DEPTH);
      for (int i = 0; i < NR; i++) begin
         if (gate[i] && src_q[i].size() > 0) begin
            req_valid[i]          = 1'b1;
            req_data[i*DW +: DW]  = src_q[i][0][7:0];
            req_last[i]           = src_q[i][0][8];
         end else begin
            req_valid[i] = 1'b0;
            req_last[i]  = 1'b0;
         end
      end
      #1;
      check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      if (full) check("we_while_full", 32'(write_enable), 32'd0);
      if (write_enable) begin
         g = int'(grant_id);
         check("we_handshake", 32'(req_valid[g] & req_ready[g] & grant_valid), 32'd1);
         check("exp_avail", 32'(exp_q[g].size() > 0), 32'd1);
         if (exp_q[g].size() > 0) begin
            e = exp_q[g].pop_front();
            check("data_order", 32'(write_data), 32'(e));
         end
         burst_beats++;
         check("burst_len", 32'(burst_beats <= int'(MB)), 32'd1);
         fifo_q.push_back(write_data);
         wr_log.push_back(g);
      end
      for (int i = 0; i < NR; i++) begin
         if (req_valid[i] && req_ready[i]) void'(src_q[i].pop_front());
      end
      if (grant_valid && !prev_gv) grant_log.push_back(int'(grant_id));
      if (!grant_valid && prev_gv) begin
         len_log.push_back(burst_beats);
         burst_beats = 0;
      end
      prev_gv = grant_valid;
      if (rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (src_pending() && n < budget) begin
         step();
         n++;
      end
      check("drain_done", 32'(src_pending()), 32'd0);
      repeat (3) step();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn      = 1'b0;
      gate      = '0;
      req_valid = '0;
      req_last  = '0;
      full      = 1'b0;
      rd        = 1'b0;
      repeat (2) @(negedge clk);
      clear_model();
      rstn = 1'b1;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int total;
      n_checks  = 0;
      n_pass    = 0;
      rstn      = 1'b0;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      full      = 1'b0;
      gate      = '0;
      rd        = 1'b0;
      for (int i = 0; i < NR; i++) seq[i] = 0;
      clear_model();

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_gv", 32'(grant_valid), 32'd0);
      check("rst_gid", 32'(grant_id), 32'd0);
      check("rst_we", 32'(write_enable), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      rstn = 1'b1;

      // 1: single three-beat burst on req1, then pointer lands on 2
      rd = 1'b1;
      queue_burst(1, 3, 1'b1);
      gate = 4'b0010;
      step();
      check("t1_idle_gv", 32'(grant_valid), 32'd0);
      check("t1_idle_ready", 32'(req_ready), 32'd0);
      step();
      check("t1_gv", 32'(grant_valid), 32'd1);
      check("t1_gid", 32'(grant_id), 32'd1);
      check("t1_we_first", 32'(write_enable), 32'd1);
      step();
      step();
      check("t1_we_last", 32'(write_enable), 32'd1);
      step();
      check("t1_release_gv", 32'(grant_valid), 32'd0);
      check("t1_hold_gid", 32'(grant_id), 32'd1);
      check("t1_release_we", 32'(write_enable), 32'd0);
      grant_log.delete();
      queue_burst(0, 1, 1'b1);
      queue_burst(2, 1, 1'b1);
      queue_burst(3, 1, 1'b1);
      gate = 4'b1101;
      drain(50);
      check("t1_rr_count", 32'(grant_log.size()), 32'd3);
      check("t1_rr_first", 32'(grant_log[0]), 32'd2);
      check("t1_rr_second", 32'(grant_log[1]), 32'd3);
      check("t1_rr_third", 32'(grant_log[2]), 32'd0);

      // 2: all four requesting without last -> 4-beat bursts in round-robin order
      do_reset();
      rd = 1'b1;
      for (int i = 0; i < NR; i++) queue_burst(i, 8, 1'b0);
      gate = '1;
      drain(200);
      check("t2_ngrants", 32'(grant_log.size()), 32'd8);
      for (int k = 0; k < grant_log.size(); k++) check("t2_grant", 32'(grant_log[k]), 32'(k % 4));
      check("t2_nbursts", 32'(len_log.size()), 32'd8);
      for (int k = 0; k < len_log.size(); k++) check("t2_len", 32'(len_log[k]), 32'd4);
      check("t2_nwrites", 32'(wr_log.size()), 32'd32);
      for (int k = 0; k < wr_log.size(); k++) check("t2_interleave", 32'(wr_log[k]), 32'((k / 4) % 4));

      // 3: fill the FIFO from req0 with the consumer off
      do_reset();
      queue_burst(0, 20, 1'b0);
      gate = 4'b0001;
      n = 0;
      while (fifo_q.size() < DEPTH && n < 100) begin
         step();
         n++;
      end
      check("t3_filled", 32'(fifo_q.size()), 32'(DEPTH));
      repeat (3) begin
         step();
         check("t3_we_full", 32'(write_enable), 32'd0);
         check("t3_ready_full", 32'(req_ready[0]), 32'd0);
      end
      check("t3_remaining", 32'(src_q[0].size()), 32'd4);
      rd = 1'b1;
      step();
      rd = 1'b0;
      repeat (6) step();
      check("t3_one_more", 32'(src_q[0].size()), 32'd3);
      check("t3_refilled", 32'(fifo_q.size()), 32'(DEPTH));

      // 4: req2 stalls after one beat -> forced release on the 8th idle cycle, req3 next
      do_reset();
      rd = 1'b1;
      queue_burst(2, 1, 1'b0);
      queue_burst(3, 2, 1'b1);
      gate = 4'b1100;
      step();
      check("t4_idle_gv", 32'(grant_valid), 32'd0);
      step();
      check("t4_gid", 32'(grant_id), 32'd2);
      check("t4_we", 32'(write_enable), 32'd1);
      for (int k = 0; k < int'(ST); k++) begin
         step();
         check("t4_stall_gv", 32'(grant_valid), 32'd1);
         check("t4_stall_we", 32'(write_enable), 32'd0);
      end
      step();
      check("t4_released", 32'(grant_valid), 32'd0);
      step();
      check("t4_next_gv", 32'(grant_valid), 32'd1);
      check("t4_next_gid", 32'(grant_id), 32'd3);
      drain(50);

      // 5: move pointer off zero, then reset in the middle of a req0 burst
      do_reset();
      rd = 1'b1;
      queue_burst(2, 1, 1'b1);
      gate = 4'b0100;
      drain(50);
      queue_burst(0, 4, 1'b0);
      gate = 4'b0001;
      step();
      step();
      check("t5_gid", 32'(grant_id), 32'd0);
      check("t5_we_beat0", 32'(write_enable), 32'd1);
      step();
      @(negedge clk);
      rstn = 1'b0;
      #1;
      check("t5_rst_we", 32'(write_enable), 32'd0);
      check("t5_rst_ready", 32'(req_ready), 32'd0);
      check("t5_rst_gv", 32'(grant_valid), 32'd0);
      check("t5_rst_gid", 32'(grant_id), 32'd0);
      repeat (2) begin
         @(negedge clk);
         #1;
         check("t5_rst_hold_we", 32'(write_enable), 32'd0);
      end
      clear_model();
      rstn = 1'b1;
      queue_burst(0, 1, 1'b1);
      queue_burst(3, 1, 1'b1);
      gate = 4'b1001;
      drain(50);
      check("t5_ngrants", 32'(grant_log.size()), 32'd2);
      check("t5_first", 32'(grant_log[0]), 32'd0);
      check("t5_second", 32'(grant_log[1]), 32'd3);

      // 6: random valid/last/full traffic
      do_reset();
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < NR; i++) begin
            if (src_q[i].size() < 4 && $urandom_range(0, 3) != 0)
               queue_burst(i, 1, ($urandom_range(0, 4) == 0));
            gate[i] = ($urandom_range(0, 4) != 0);
         end
         rd = ($urandom_range(0, 2) == 0);
         step();
      end
      gate = '1;
      rd   = 1'b1;
      drain(2000);
      total = 0;
      for (int i = 0; i < NR; i++) total += exp_q[i].size();
      check("t6_exp_left", 32'(total), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
